// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider reconfiguration controller.
// Holds the FSM state encoding, the ratio width, the smallest legal ratio
// and the default values of the top-level parameters.
package div_ctrl_pkg;

    localparam int              DIV_W        = 8;
    localparam logic [DIV_W-1:0] DIV_MIN     = 8'd2;
    localparam logic [DIV_W-1:0] RST_DIV_DEF = 8'd2;
    localparam int              GATE_CYC_DEF = 2;
    localparam int              TMO_CYC_DEF  = 600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATE   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACK    = 3'd5,
        ST_WAITLO = 3'd6
    } state_t;

endpackage

// File: rtl/div_cfg_ctrl_if.sv
// Configuration request handshake between a requester and div_cfg_ctrl.
//
// Handshake (four-phase): the requester raises cfg_req with cfg_val and
// holds both until it sees the one-cycle cfg_ack pulse; cfg_err is valid
// in that same cycle. The requester then drops cfg_req, and the controller
// will not start another transaction until it has seen cfg_req low.
// cfg_busy is high from acceptance through the ACK cycle.
//
//   cfg_req   requester -> controller  request level
//   cfg_val   requester -> controller  requested divide ratio
//   cfg_ack   controller -> requester  completion pulse
//   cfg_err   controller -> requester  rejected ratio or timeout
//   cfg_busy  controller -> requester  transaction in progress
interface div_cfg_ctrl_if;
    import div_ctrl_pkg::*;

    logic             cfg_req;
    logic [DIV_W-1:0] cfg_val;
    logic             cfg_ack;
    logic             cfg_err;
    logic             cfg_busy;

    modport master (
        output cfg_req,
        output cfg_val,
        input  cfg_ack,
        input  cfg_err,
        input  cfg_busy
    );

    modport slave (
        input  cfg_req,
        input  cfg_val,
        output cfg_ack,
        output cfg_err,
        output cfg_busy
    );

endinterface

// File: rtl/div_ctrl_tmo.sv
// Saturating timeout counter shared by the DRAIN and SETTLE waits.
//
//   clk      block clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear (takes priority over en)
//   en       count one cycle
//   expired  count has reached TMO_CYC; the counter holds there
module div_ctrl_tmo #(
    parameter int TMO_CYC = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/div_cfg_ctrl.sv
// Glitch-free reconfiguration controller for an odd/even clock divider.
// A new ratio is accepted over a four-phase handshake, the divider is let
// finish its current output period, held off for GATE_CYC cycles, then the
// ratio and the enable are updated on the same edge. The controller then
// waits one full period at the new ratio before acknowledging.
//
//   clk        block clock (also clocks the divider)
//   rst_n      asynchronous active-low reset
//   cfg        request handshake (slave side)
//   div_cfg    registered ratio to the divider
//   div_en     divider run enable
//   div_done   divider end-of-period pulse
//   state_dbg  current FSM state
module div_cfg_ctrl
    import div_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0] RST_DIV  = RST_DIV_DEF,
    parameter int               GATE_CYC = GATE_CYC_DEF,
    parameter int               TMO_CYC  = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    div_cfg_ctrl_if.slave    cfg,
    output logic [DIV_W-1:0] div_cfg,
    output logic             div_en,
    input  logic             div_done,
    output state_t           state_dbg
);

    localparam int            GW       = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam logic [GW-1:0] GATE_END = GW'(GATE_CYC - 1);

    state_t           state;
    logic [DIV_W-1:0] shadow;
    logic [GW-1:0]    gate_cnt;
    logic             err_flag;
    logic             tmo_en;
    logic             tmo_clr;
    logic             tmo_expired;

    // The counter runs only in the two waiting states and is held clear
    // elsewhere, so it always starts from zero on entry to either.
    assign tmo_en  = (state == ST_DRAIN) || (state == ST_SETTLE);
    assign tmo_clr = !tmo_en;

    div_ctrl_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shadow       <= RST_DIV;
            div_cfg      <= RST_DIV;
            div_en       <= 1'b1;
            gate_cnt     <= '0;
            err_flag     <= 1'b0;
            cfg.cfg_ack  <= 1'b0;
            cfg.cfg_err  <= 1'b0;
            cfg.cfg_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg.cfg_req) begin
                        cfg.cfg_busy <= 1'b1;
                        if (cfg.cfg_val >= DIV_MIN) begin
                            shadow   <= cfg.cfg_val;
                            err_flag <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            // Illegal ratio: divider untouched, answer at once.
                            err_flag    <= 1'b1;
                            cfg.cfg_ack <= 1'b1;
                            cfg.cfg_err <= 1'b1;
                            state       <= ST_ACK;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Stop the divider only at a period boundary; a stuck
                    // divider is stopped anyway after the timeout.
                    if (div_done || tmo_expired) begin
                        if (!div_done) begin
                            err_flag <= 1'b1;
                        end
                        div_en   <= 1'b0;
                        gate_cnt <= '0;
                        state    <= ST_GATE;
                    end
                end

                ST_GATE: begin
                    if (gate_cnt == GATE_END) begin
                        state <= ST_LOAD;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                    end
                end

                ST_LOAD: begin
                    // Ratio and enable move together so the divider never
                    // runs while its ratio is changing.
                    div_cfg <= shadow;
                    div_en  <= 1'b1;
                    state   <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (div_done || tmo_expired) begin
                        cfg.cfg_ack <= 1'b1;
                        cfg.cfg_err <= err_flag || !div_done;
                        state       <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    cfg.cfg_ack  <= 1'b0;
                    cfg.cfg_err  <= 1'b0;
                    cfg.cfg_busy <= 1'b0;
                    state        <= ST_WAITLO;
                end

                ST_WAITLO: begin
                    if (!cfg.cfg_req) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Bench for div_cfg_ctrl: a behavioural divider drives div_done, a
// requester task drives the handshake and pushes the expected completion
// into exp_q, and a monitor pops and compares on every cfg_ack.
module tb_div_cfg_ctrl;
    import div_ctrl_pkg::*;

    localparam int GATE_CYC = 2;
    localparam int TMO_CYC  = 600;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_cfg_ctrl_if cfg_bus ();
    logic [7:0] div_cfg;
    logic       div_en;
    logic       div_done;
    state_t     state_dbg;

    div_cfg_ctrl #(
        .RST_DIV  (8'd2),
        .GATE_CYC (GATE_CYC),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg_bus),
        .div_cfg   (div_cfg),
        .div_en    (div_en),
        .div_done  (div_done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry: {cfg_err, div_en fell during transaction, div_cfg}
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_div;
    logic [7:0] rise_exp;
    bit         en_fell;
    bit         done_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- divider model ----------------
    // Stopped (and output low) while div_en is low; otherwise one done
    // pulse every div_cfg cycles.
    int dcnt = 0;
    always @(negedge clk) begin
        if (!div_en || done_off) begin
            dcnt     = 0;
            div_done = 1'b0;
        end else begin
            dcnt = dcnt + 1;
            if (dcnt >= int'(div_cfg)) begin
                dcnt     = 0;
                div_done = 1'b1;
            end else begin
                div_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic       prev_en;
    logic [7:0] prev_cfg;
    int         low_len;
    logic [9:0] exp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en  = div_en;
            prev_cfg = div_cfg;
            low_len  = 0;
        end else begin
            if (prev_en && div_en) begin
                chk("div_cfg_stable_while_en", 32'(div_cfg), 32'(prev_cfg));
            end
            if (!div_en) begin
                en_fell = 1'b1;
                low_len++;
            end
            if (!prev_en && div_en) begin
                chk("rise_div_cfg", 32'(div_cfg), 32'(rise_exp));
                chk("en_low_cycles", 32'(low_len), 32'(GATE_CYC + 1));
                low_len = 0;
            end
            if (cfg_bus.cfg_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(1), 32'(0));
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("ack_err", 32'(cfg_bus.cfg_err), 32'(exp_e[9]));
                    chk("ack_en_fell", 32'(en_fell), 32'(exp_e[8]));
                    chk("ack_div_cfg", 32'(div_cfg), 32'(exp_e[7:0]));
                    chk("ack_busy", 32'(cfg_bus.cfg_busy), 32'(1));
                end
            end
            prev_en  = div_en;
            prev_cfg = div_cfg;
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [7:0] v, input bit tie0, input bit scramble, input int hold);
        bit got;
        bit exp_err;
        logic [7:0] exp_div;
        exp_err = (v < 8'd2) || tie0;
        exp_div = (v >= 8'd2) ? v : model_div;
        exp_q.push_back({exp_err, (v >= 8'd2), exp_div});
        model_div = exp_div;
        rise_exp  = v;
        done_off  = tie0;
        @(negedge clk);
        en_fell         = 1'b0;
        cfg_bus.cfg_req = 1'b1;
        cfg_bus.cfg_val = v;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cfg_bus.cfg_ack) begin
                got = 1'b1;
                break;
            end
            if (scramble && cfg_bus.cfg_busy) cfg_bus.cfg_val = 8'($urandom);
        end
        if (!got) chk("ack_timeout", 32'(0), 32'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("waitlo_busy", 32'(cfg_bus.cfg_busy), 32'(0));
            chk("waitlo_state", 32'(state_dbg), 32'(ST_WAITLO));
        end
        @(negedge clk);
        cfg_bus.cfg_req = 1'b0;
        done_off        = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n           = 1'b0;
        cfg_bus.cfg_req = 1'b0;
        cfg_bus.cfg_val = 8'd0;
        div_done        = 1'b0;
        model_div       = 8'd2;
        rise_exp        = 8'd2;
        en_fell         = 1'b0;

        @(negedge clk);
        chk("rst_div_cfg", 32'(div_cfg), 32'(2));
        chk("rst_div_en", 32'(div_en), 32'(1));
        chk("rst_ack", 32'(cfg_bus.cfg_ack), 32'(0));
        chk("rst_err", 32'(cfg_bus.cfg_err), 32'(0));
        chk("rst_busy", 32'(cfg_bus.cfg_busy), 32'(0));
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_req(8'h0b, 1'b0, 1'b0, 0);
        do_req(8'h01, 1'b0, 1'b0, 0);
        do_req(8'h00, 1'b0, 1'b0, 0);
        chk("reject_keeps_div", 32'(div_cfg), 32'(8'h0b));
        do_req(8'h05, 1'b1, 1'b0, 0);
        do_req(8'h04, 1'b0, 1'b0, 20);

        // Reset while gating: transaction abandoned, reset values forced.
        rise_exp = 8'h03;
        @(negedge clk);
        cfg_bus.cfg_req = 1'b1;
        cfg_bus.cfg_val = 8'h03;
        for (int i = 0; i < 200; i++) begin
            if (state_dbg == ST_GATE) break;
            @(negedge clk);
        end
        chk("reached_gate", 32'(state_dbg), 32'(ST_GATE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_div_en", 32'(div_en), 32'(1));
        chk("midrst_div_cfg", 32'(div_cfg), 32'(2));
        chk("midrst_ack", 32'(cfg_bus.cfg_ack), 32'(0));
        chk("midrst_busy", 32'(cfg_bus.cfg_busy), 32'(0));
        cfg_bus.cfg_req = 1'b0;
        model_div = 8'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_req(8'h03, 1'b0, 1'b0, 0);

        do_req(8'h07, 1'b0, 1'b1, 0);
        chk("scramble_div_cfg", 32'(div_cfg), 32'(7));
        do_req(8'h07, 1'b0, 1'b0, 0);

        for (int k = 0; k < 10; k++) begin
            do_req(8'($urandom_range(0, 24)), 1'b0, 1'b0, int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
